// File: rtl/rename_pkg.sv
// Shared types and default sizes for the rename map and its checkpoint pool.
package rename_pkg;

  localparam int unsigned NUM_AREG_DEF = 32;
  localparam int unsigned NUM_PREG_DEF = 128;
  localparam int unsigned NUM_CKPT_DEF = 4;
  localparam int unsigned AREG_W       = 5;
  localparam int unsigned PREG_W_DEF   = $clog2(NUM_PREG_DEF);
  localparam int unsigned CKPT_W_DEF   = $clog2(NUM_CKPT_DEF);

  typedef logic [AREG_W-1:0]     areg_t;
  typedef logic [PREG_W_DEF-1:0] preg_t;
  typedef logic [CKPT_W_DEF-1:0] ckpt_id_t;
  typedef preg_t                 map_t [NUM_AREG_DEF];

endpackage

// File: rtl/rename_ckpt_alloc.sv
// Checkpoint slot bookkeeping: valid bits, allocation pointer, full flag and
// clearing of the mispredicted slot plus everything allocated after it.
module rename_ckpt_alloc #(
  parameter  int unsigned NUM_CKPT = 4,
  localparam int unsigned CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ckpt_req_i,
  input  logic              res_valid_i,
  input  logic [CKPT_W-1:0] res_id_i,
  input  logic              res_mispredict_i,
  output logic [CKPT_W-1:0] ckpt_id_o,
  output logic              ckpt_full_o,
  output logic              take_o,
  output logic              restore_o
);

  logic [NUM_CKPT-1:0] ck_valid_q, ck_valid_d;
  logic [CKPT_W-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic                misp_c;
  int unsigned         span_c;

  assign ckpt_id_o   = alloc_ptr_q;
  assign ckpt_full_o = ck_valid_q[alloc_ptr_q];
  assign misp_c      = res_valid_i && res_mispredict_i;
  assign restore_o   = misp_c && ck_valid_q[res_id_i];
  assign take_o      = ckpt_req_i && !ckpt_full_o && !misp_c;

  // Next valid bits and pointer; a mispredict overrides resolve and allocation.
  always_comb begin
    ck_valid_d  = ck_valid_q;
    alloc_ptr_d = alloc_ptr_q;
    span_c      = (32'(alloc_ptr_q) + NUM_CKPT - 32'(res_id_i)) % NUM_CKPT;
    if (restore_o) begin
      // span 0 with a valid res_id means the ring is full: clear every slot
      for (int unsigned i = 0; i < NUM_CKPT; i++) begin
        if (span_c == 0 || ((i + NUM_CKPT - 32'(res_id_i)) % NUM_CKPT) < span_c) begin
          ck_valid_d[i] = 1'b0;
        end
      end
      alloc_ptr_d = res_id_i;
    end else if (!misp_c) begin
      if (res_valid_i) begin
        ck_valid_d[res_id_i] = 1'b0;
      end
      if (take_o) begin
        ck_valid_d[alloc_ptr_q] = 1'b1;
        alloc_ptr_d = (alloc_ptr_q == CKPT_W'(NUM_CKPT - 1)) ? '0
                                                              : alloc_ptr_q + CKPT_W'(1);
      end
    end
  end

  // Slot state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ck_valid_q  <= '0;
      alloc_ptr_q <= '0;
    end else begin
      ck_valid_q  <= ck_valid_d;
      alloc_ptr_q <= alloc_ptr_d;
    end
  end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register alias table with multi-lane rename, combinational lookups and a
// pool of branch checkpoints restored in one cycle on mispredict.
// Optional: define RENAME_INTRA_BYPASS_EN to forward older-lane destinations
// to younger-lane lookups within one rename group.
module rename_map_ckpt
  import rename_pkg::*;
#(
  parameter  int unsigned NUM_AREG = NUM_AREG_DEF,
  parameter  int unsigned NUM_PREG = NUM_PREG_DEF,
  parameter  int unsigned RENAME_W = 2,
  parameter  int unsigned NUM_CKPT = NUM_CKPT_DEF,
  localparam int unsigned PREG_W   = $clog2(NUM_PREG),
  localparam int unsigned CKPT_W   = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
  localparam int unsigned LANE_W   = (RENAME_W > 1) ? $clog2(RENAME_W) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [RENAME_W-1:0]              ren_valid_i,
  input  areg_t [RENAME_W-1:0]             ren_rd_i,
  input  logic [RENAME_W-1:0][PREG_W-1:0]  ren_pd_i,
  input  areg_t [RENAME_W-1:0]             rs1_i,
  input  areg_t [RENAME_W-1:0]             rs2_i,
  output logic [RENAME_W-1:0][PREG_W-1:0]  ps1_o,
  output logic [RENAME_W-1:0][PREG_W-1:0]  ps2_o,
  output logic [RENAME_W-1:0][PREG_W-1:0]  pd_old_o,
  input  logic                             ckpt_req_i,
  input  logic [LANE_W-1:0]                ckpt_lane_i,
  output logic [CKPT_W-1:0]                ckpt_id_o,
  output logic                             ckpt_full_o,
  input  logic                             res_valid_i,
  input  logic [CKPT_W-1:0]                res_id_i,
  input  logic                             res_mispredict_i
);

  logic [PREG_W-1:0] map_q  [NUM_AREG];
  logic [PREG_W-1:0] map_d  [NUM_AREG];
  logic [PREG_W-1:0] snap_d [NUM_AREG];
  logic [PREG_W-1:0] snap_q [NUM_CKPT][NUM_AREG];
  logic              take_c;
  logic              restore_c;
  logic              misp_c;

  assign misp_c = res_valid_i && res_mispredict_i;

  rename_ckpt_alloc #(
    .NUM_CKPT (NUM_CKPT)
  ) u_alloc (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .ckpt_req_i       (ckpt_req_i),
    .res_valid_i      (res_valid_i),
    .res_id_i         (res_id_i),
    .res_mispredict_i (res_mispredict_i),
    .ckpt_id_o        (ckpt_id_o),
    .ckpt_full_o      (ckpt_full_o),
    .take_o           (take_c),
    .restore_o        (restore_c)
  );

  // Apply lanes oldest first so the youngest colliding write wins; snapshot
  // image is the map right after the branch lane's own write.
  always_comb begin
    map_d  = map_q;
    snap_d = map_q;
    for (int l = 0; l < RENAME_W; l++) begin
      if (ren_valid_i[l] && ren_rd_i[l] != '0) begin
        map_d[ren_rd_i[l]] = ren_pd_i[l];
      end
      if (LANE_W'(l) == ckpt_lane_i) begin
        snap_d = map_d;
      end
    end
    map_d[0]  = '0;
    snap_d[0] = '0;
  end

  // Source and old-destination lookups; x0 always reads p0.
  always_comb begin
    for (int k = 0; k < RENAME_W; k++) begin
      ps1_o[k]    = map_q[rs1_i[k]];
      ps2_o[k]    = map_q[rs2_i[k]];
      pd_old_o[k] = map_q[ren_rd_i[k]];
`ifdef RENAME_INTRA_BYPASS_EN
      for (int j = 0; j < k; j++) begin
        if (ren_valid_i[j] && ren_rd_i[j] != '0) begin
          if (ren_rd_i[j] == rs1_i[k])    ps1_o[k]    = ren_pd_i[j];
          if (ren_rd_i[j] == rs2_i[k])    ps2_o[k]    = ren_pd_i[j];
          if (ren_rd_i[j] == ren_rd_i[k]) pd_old_o[k] = ren_pd_i[j];
        end
      end
`endif
      if (rs1_i[k] == '0)    ps1_o[k]    = '0;
      if (rs2_i[k] == '0)    ps2_o[k]    = '0;
      if (ren_rd_i[k] == '0) pd_old_o[k] = '0;
    end
  end

  // Map register: reset to identity, restore on mispredict, else take writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        map_q[i] <= PREG_W'(i);
      end
    end else if (misp_c) begin
      if (restore_c) begin
        map_q <= snap_q[res_id_i];
      end
    end else begin
      map_q <= map_d;
    end
  end

  // Snapshot storage; contents are only meaningful while the slot is valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i && take_c) begin
      snap_q[ckpt_id_o] <= snap_d;
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Randomized plus directed bench for rename_map_ckpt against a behavioural
// map/checkpoint model.
module tb_rename_map_ckpt;
  import rename_pkg::*;

  localparam int unsigned RW = 2;
  localparam int unsigned NA = 32;
  localparam int unsigned NP = 128;
  localparam int unsigned NC = 4;
  localparam int unsigned PW = 7;
  localparam int unsigned CW = 2;

  logic                    clk;
  logic                    reset;
  logic [RW-1:0]           ren_valid;
  logic [RW-1:0][4:0]      ren_rd;
  logic [RW-1:0][PW-1:0]   ren_pd;
  logic [RW-1:0][4:0]      rs1;
  logic [RW-1:0][4:0]      rs2;
  logic [RW-1:0][PW-1:0]   ps1;
  logic [RW-1:0][PW-1:0]   ps2;
  logic [RW-1:0][PW-1:0]   pd_old;
  logic                    ckpt_req;
  logic [0:0]              ckpt_lane;
  logic [CW-1:0]           ckpt_id;
  logic                    ckpt_full;
  logic                    res_valid;
  logic [CW-1:0]           res_id;
  logic                    res_mispredict;

  rename_map_ckpt #(
    .NUM_AREG (NA),
    .NUM_PREG (NP),
    .RENAME_W (RW),
    .NUM_CKPT (NC)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .ren_valid_i      (ren_valid),
    .ren_rd_i         (ren_rd),
    .ren_pd_i         (ren_pd),
    .rs1_i            (rs1),
    .rs2_i            (rs2),
    .ps1_o            (ps1),
    .ps2_o            (ps2),
    .pd_old_o         (pd_old),
    .ckpt_req_i       (ckpt_req),
    .ckpt_lane_i      (ckpt_lane),
    .ckpt_id_o        (ckpt_id),
    .ckpt_full_o      (ckpt_full),
    .res_valid_i      (res_valid),
    .res_id_i         (res_id),
    .res_mispredict_i (res_mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Reference state: architectural map, snapshot images, live slots, pointer.
  int mmap [NA];
  int msnap [NC][NA];
  bit mckv [NC];
  int mptr;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_look(input int r, input int k);
    int v;
    if (r == 0) return 0;
    v = mmap[r];
`ifdef RENAME_INTRA_BYPASS_EN
    for (int j = 0; j < k; j++) begin
      if (ren_valid[j] && ren_rd[j] != 0 && int'(ren_rd[j]) == r) v = int'(ren_pd[j]);
    end
`else
    if (k < 0) v = 0;
`endif
    return v;
  endfunction

  task automatic idle();
    ren_valid = '0; ren_rd = '0; ren_pd = '0; rs1 = '0; rs2 = '0;
    ckpt_req = 1'b0; ckpt_lane = '0;
    res_valid = 1'b0; res_id = '0; res_mispredict = 1'b0;
  endtask

  // Check outputs against the model, then advance model and DUT one edge.
  task automatic cycle();
    int  nmap [NA];
    int  cur [NA];
    int  snapv [NA];
    bit  nckv [NC];
    int  nptr;
    int  s;
    bit  take;
    @(negedge clk);
    for (int k = 0; k < RW; k++) begin
      check($sformatf("ps1[%0d]", k),    int'(ps1[k]),    m_look(int'(rs1[k]), k));
      check($sformatf("ps2[%0d]", k),    int'(ps2[k]),    m_look(int'(rs2[k]), k));
      check($sformatf("pd_old[%0d]", k), int'(pd_old[k]), m_look(int'(ren_rd[k]), k));
    end
    check("ckpt_full", int'(ckpt_full), int'(mckv[mptr]));
    check("ckpt_id",   int'(ckpt_id),   mptr);

    nmap = mmap;
    nckv = mckv;
    nptr = mptr;
    if (reset) begin
      for (int i = 0; i < NA; i++) nmap[i] = i;
      for (int i = 0; i < NC; i++) nckv[i] = 1'b0;
      nptr = 0;
    end else if (res_valid && res_mispredict) begin
      if (mckv[res_id]) begin
        nmap = msnap[res_id];
        s = int'(res_id);
        do begin
          nckv[s] = 1'b0;
          s = (s + 1) % NC;
        end while (s != mptr);
        nptr = int'(res_id);
      end
    end else begin
      take = ckpt_req && !mckv[mptr];
      if (res_valid) nckv[res_id] = 1'b0;
      cur   = mmap;
      snapv = mmap;
      for (int l = 0; l < RW; l++) begin
        if (ren_valid[l] && ren_rd[l] != 0) cur[ren_rd[l]] = int'(ren_pd[l]);
        if (l == int'(ckpt_lane)) snapv = cur;
      end
      nmap = cur;
      if (take) begin
        msnap[mptr] = snapv;
        nckv[mptr]  = 1'b1;
        nptr        = (mptr + 1) % NC;
      end
    end
    @(posedge clk);
    mmap = nmap;
    mckv = nckv;
    mptr = nptr;
    #1;
  endtask

  initial begin
    int q [$];
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < NA; i++) mmap[i] = i;
    for (int i = 0; i < NC; i++) mckv[i] = 1'b0;
    mptr = 0;
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;

    // Identity map after reset
    rs1[0] = 5'd5; rs1[1] = 5'd0; #1;
    check("rst_ps1_x5", int'(ps1[0]), 5);
    check("rst_ps1_x0", int'(ps1[1]), 0);
    check("rst_full",   int'(ckpt_full), 0);
    check("rst_id",     int'(ckpt_id), 0);
    cycle();

    // Same-rd collision: younger lane wins
    idle();
    ren_valid = 2'b11; ren_rd[0] = 5'd3; ren_rd[1] = 5'd3;
    ren_pd[0] = 7'd40; ren_pd[1] = 7'd41; #1;
`ifdef RENAME_INTRA_BYPASS_EN
    check("byp_pd_old1", int'(pd_old[1]), 40);
`else
    check("nobyp_pd_old1", int'(pd_old[1]), 3);
`endif
    cycle();
    idle(); rs1[0] = 5'd3; #1;
    check("waw_ps1_x3", int'(ps1[0]), 41);
    cycle();

    // Checkpoint on lane 0 captures only lane 0's write
    idle();
    ckpt_req = 1'b1; ckpt_lane = 1'b0;
    ren_valid = 2'b11; ren_rd[0] = 5'd7; ren_rd[1] = 5'd7;
    ren_pd[0] = 7'd50; ren_pd[1] = 7'd51;
    cycle();
    idle(); rs1[0] = 5'd7; #1;
    check("x7_latest", int'(ps1[0]), 51);
    check("ckpt_id_after_take", int'(ckpt_id), 1);
    cycle();
    idle(); res_valid = 1'b1; res_mispredict = 1'b1; res_id = 2'd0;
    cycle();
    idle(); rs1[0] = 5'd7; #1;
    check("x7_restored", int'(ps1[0]), 50);
    check("ptr_after_misp0", int'(ckpt_id), 0);
    cycle();

    // Fill all slots, overflow request ignored, out-of-order frees
    idle(); ckpt_req = 1'b1;
    repeat (4) cycle();
    check("full_after4", int'(ckpt_full), 1);
    cycle();
    idle(); #1;
    check("fifth_ignored_id", int'(ckpt_id), 0);
    res_valid = 1'b1; res_id = 2'd2;
    cycle();
    idle(); #1;
    check("free2_still_full", int'(ckpt_full), 1);
    res_valid = 1'b1; res_id = 2'd0;
    cycle();
    idle(); #1;
    check("free0_not_full", int'(ckpt_full), 0);

    // Mispredict on a middle slot frees younger ones and drops renames
    reset = 1'b1; cycle(); reset = 1'b0;
    idle(); ckpt_req = 1'b1;
    repeat (3) cycle();
    idle(); res_valid = 1'b1; res_mispredict = 1'b1; res_id = 2'd1;
    ren_valid = 2'b01; ren_rd[0] = 5'd9; ren_pd[0] = 7'd99;
    cycle();
    idle(); rs1[0] = 5'd9; #1;
    check("x9_dropped", int'(ps1[0]), 9);
    check("ptr_misp1",  int'(ckpt_id), 1);
    check("full_misp1", int'(ckpt_full), 0);

    // Reset with live checkpoints returns everything to the initial state
    idle(); ckpt_req = 1'b1;
    ren_valid = 2'b01; ren_rd[0] = 5'd4; ren_pd[0] = 7'd77;
    repeat (2) cycle();
    idle(); reset = 1'b1;
    cycle();
    reset = 1'b0; rs1[0] = 5'd4; #1;
    check("rst_mid_x4", int'(ps1[0]), 4);
    check("rst_mid_id", int'(ckpt_id), 0);
    check("rst_mid_full", int'(ckpt_full), 0);
    cycle();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      for (int l = 0; l < RW; l++) begin
        ren_valid[l] = $urandom_range(0, 3) != 0;
        ren_rd[l]    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        ren_pd[l]    = 7'($urandom_range(0, NP - 1));
        rs1[l]       = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        rs2[l]       = 5'($urandom_range(0, 31));
      end
      ckpt_req  = $urandom_range(0, 2) == 0;
      ckpt_lane = 1'($urandom_range(0, RW - 1));
      q.delete();
      for (int i = 0; i < NC; i++) if (mckv[i]) q.push_back(i);
      if (q.size() != 0 && $urandom_range(0, 3) == 0) begin
        res_valid      = 1'b1;
        res_id         = CW'(q[$urandom_range(0, q.size() - 1)]);
        res_mispredict = $urandom_range(0, 2) == 0;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
